// File: rtl/writeback_queue.sv
// Writeback stage: merges ALU and LSU results through a small FIFO onto the
// single register-file write port, and reports which registers have writes in flight.
module writeback_queue #(
    parameter int LEN_REG   = 32,
    parameter int LEN_REGNO = 4,
    parameter int NUM_REGS  = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    input  logic [LEN_REGNO-1:0] alu_r_i,
    input  logic [LEN_REG-1:0]   alu_data_i,
    output logic                 alu_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [LEN_REGNO-1:0] lsu_r_i,
    input  logic [LEN_REG-1:0]   lsu_data_i,
    output logic                 lsu_ready_o,
    output logic                 wb_o,
    output logic [LEN_REGNO-1:0] wb_r_o,
    output logic [LEN_REG-1:0]   result_o,
    output logic [NUM_REGS-1:0]  pending_o,
    output logic                 empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [LEN_REGNO-1:0] regno_q [DEPTH];
    logic [LEN_REGNO-1:0] regno_d [DEPTH];
    logic [LEN_REG-1:0]   data_q  [DEPTH];
    logic [LEN_REG-1:0]   data_d  [DEPTH];

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wb_q, wb_d;
    logic [LEN_REGNO-1:0] wb_r_q, wb_r_d;
    logic [LEN_REG-1:0]   result_q, result_d;

    logic [CNT_W-1:0]     free;
    logic                 alu_xfer, lsu_xfer, pop;
    logic [PTR_W-1:0]     lsu_slot;
    logic [PTR_W-1:0]     offset;

    // Readies use the count at cycle start; a same-cycle pop frees nothing yet.
    always_comb begin
        free        = DEPTH_C - count_q;
        alu_ready_o = (free != '0);
        lsu_ready_o = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !alu_valid_i);
        alu_xfer    = alu_valid_i && alu_ready_o;
        lsu_xfer    = lsu_valid_i && lsu_ready_o;
        pop         = (count_q != '0);
        lsu_slot    = alu_xfer ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    end

    always_comb begin
        regno_d  = regno_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(alu_xfer) + PTR_W'(lsu_xfer);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(alu_xfer) + CNT_W'(lsu_xfer) - CNT_W'(pop);
        wb_d     = pop;
        wb_r_d   = wb_r_q;
        result_d = result_q;

        // ALU lands first so a same-register LSU result retires after it.
        if (alu_xfer) begin
            regno_d[wr_ptr_q] = alu_r_i;
            data_d[wr_ptr_q]  = alu_data_i;
        end
        if (lsu_xfer) begin
            regno_d[lsu_slot] = lsu_r_i;
            data_d[lsu_slot]  = lsu_data_i;
        end
        if (pop) begin
            wb_r_d   = regno_q[rd_ptr_q];
            result_d = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wb_q     <= 1'b0;
            wb_r_q   <= '0;
            result_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wb_q     <= wb_d;
            wb_r_q   <= wb_r_d;
            result_q <= result_d;
        end
    end

    // Slot contents need no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        regno_q <= regno_d;
        data_q  <= data_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DEPTH_C);
        end
    end

    always_comb begin
        pending_o = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(offset) < count_q) begin
                pending_o[regno_q[i]] = 1'b1;
            end
        end
        if (wb_q) begin
            pending_o[wb_r_q] = 1'b1;
        end
    end

    assign wb_o     = wb_q;
    assign wb_r_o   = wb_r_q;
    assign result_o = result_q;
    assign empty_o  = (count_q == '0) && !wb_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: cycle-exact vector table plus
// scoreboard-checked streaming sequences for backpressure and pointer wrap.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i, lsu_valid_i;
    logic [3:0]  alu_r_i, lsu_r_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        alu_ready_o, lsu_ready_o;
    logic        wb_o;
    logic [3:0]  wb_r_o;
    logic [31:0] result_o;
    logic [15:0] pending_o;
    logic        empty_o;

    writeback_queue #(.LEN_REG(32), .LEN_REGNO(4), .NUM_REGS(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_r_i(alu_r_i), .alu_data_i(alu_data_i),
        .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_r_i(lsu_r_i), .lsu_data_i(lsu_data_i),
        .lsu_ready_o(lsu_ready_o),
        .wb_o(wb_o), .wb_r_o(wb_r_o), .result_o(result_o),
        .pending_o(pending_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;  logic [3:0] ar; logic [31:0] ad;
        logic        lv;  logic [3:0] lr; logic [31:0] ld;
        logic        e_ar; logic e_lr; logic e_wb;
        logic [3:0]  e_wbr; logic [31:0] e_res; logic [15:0] e_pend; logic e_empty;
    } vec_t;

    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] d;
    } item_t;

    vec_t  vecs[$];
    item_t alu_src[$];
    item_t lsu_src[$];
    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic av, input logic [3:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [3:0] lr, input logic [31:0] ld,
                       input logic e_ar, input logic e_lr, input logic e_wb,
                       input logic [3:0] e_wbr, input logic [31:0] e_res,
                       input logic [15:0] e_pend, input logic e_empty);
        vec_t v;
        v.rst = r; v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_wb = e_wb; v.e_wbr = e_wbr;
        v.e_res = e_res; v.e_pend = e_pend; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    task automatic idle_row(input logic e_wb, input logic [3:0] e_wbr, input logic [31:0] e_res,
                            input logic [15:0] e_pend, input logic e_empty);
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, e_wb, e_wbr, e_res, e_pend, e_empty);
    endtask

    // Streams alu_src / lsu_src through the DUT, holding each valid until its
    // handshake, and checks every writeback against the enqueue order.
    task automatic run_stream(input string name, input bit lsu_alt, input int total,
                              input bit check_fill);
        int cyc = 0, wbs = 0, first_wb = -1, last_wb = -1;
        bit lsu_on = 0, lsu_dropped = 0;
        item_t it;
        while ((alu_src.size() > 0 || lsu_src.size() > 0 || exp_q.size() > 0) && cyc < 300) begin
            alu_valid_i = (alu_src.size() > 0);
            alu_r_i     = alu_valid_i ? alu_src[0].r : 4'd0;
            alu_data_i  = alu_valid_i ? alu_src[0].d : 32'd0;
            if (!lsu_on && lsu_src.size() > 0 && (!lsu_alt || (cyc % 2 == 1))) lsu_on = 1;
            lsu_valid_i = lsu_on;
            lsu_r_i     = lsu_on ? lsu_src[0].r : 4'd0;
            lsu_data_i  = lsu_on ? lsu_src[0].d : 32'd0;
            @(negedge clk);
            if (wb_o) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s_unexpected_wb", name), {28'd0, wb_r_o}, 32'hFFFF_FFFF);
                end else begin
                    it = exp_q.pop_front();
                    chk($sformatf("%s_wb%0d_r", name, wbs), {28'd0, wb_r_o}, {28'd0, it.r});
                    chk($sformatf("%s_wb%0d_data", name, wbs), result_o, it.d);
                end
                if (first_wb < 0) first_wb = cyc;
                last_wb = cyc;
                wbs++;
            end
            if (!alu_ready_o) chk($sformatf("%s_lsu_ready_when_full", name), {31'd0, lsu_ready_o}, 32'd0);
            if (alu_valid_i && lsu_valid_i && alu_ready_o && !lsu_ready_o) lsu_dropped = 1;
            if (alu_valid_i && alu_ready_o) exp_q.push_back(alu_src.pop_front());
            if (lsu_valid_i && lsu_ready_o) begin
                exp_q.push_back(lsu_src.pop_front());
                lsu_on = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        alu_valid_i = 0; lsu_valid_i = 0;
        chk($sformatf("%s_cycle_budget", name), {31'd0, (cyc >= 300)}, 32'd0);
        chk($sformatf("%s_wb_count", name), wbs, total);
        if (check_fill) begin
            chk($sformatf("%s_back_to_back", name), last_wb - first_wb + 1, total);
            chk($sformatf("%s_lsu_ready_dropped", name), {31'd0, lsu_dropped}, 32'd1);
        end
    endtask

    initial begin
        rst = 1; alu_valid_i = 0; lsu_valid_i = 0;
        alu_r_i = 0; lsu_r_i = 0; alu_data_i = 0; lsu_data_i = 0;

        // Each row: inputs applied this cycle, outputs expected in this same cycle.
        idle_row(0, 4'd0, 32'h0, 16'h0000, 1);
        add(0, 1, 4'd3, 32'hAA, 0, 0, 0,               1, 1, 0, 4'd0, 32'h0, 16'h0000, 1);
        idle_row(0, 4'd0, 32'h00, 16'h0008, 0);
        idle_row(1, 4'd3, 32'hAA, 16'h0008, 0);
        idle_row(0, 4'd3, 32'hAA, 16'h0000, 1);
        add(0, 1, 4'd5, 32'h11, 1, 4'd5, 32'h22,       1, 1, 0, 4'd3, 32'hAA, 16'h0000, 1);
        idle_row(0, 4'd3, 32'hAA, 16'h0020, 0);
        idle_row(1, 4'd5, 32'h11, 16'h0020, 0);
        idle_row(1, 4'd5, 32'h22, 16'h0020, 0);
        idle_row(0, 4'd5, 32'h22, 16'h0000, 1);
        add(0, 1, 4'd1, 32'h01, 1, 4'd2, 32'h02,       1, 1, 0, 4'd5, 32'h22, 16'h0000, 1);
        add(0, 1, 4'd4, 32'h04, 1, 4'd6, 32'h06,       1, 1, 0, 4'd5, 32'h22, 16'h0006, 0);
        add(0, 1, 4'd7, 32'h07, 1, 4'd8, 32'h08,       1, 0, 1, 4'd1, 32'h01, 16'h0056, 0);
        add(0, 0, 4'd0, 32'h00, 1, 4'd8, 32'h08,       1, 1, 1, 4'd2, 32'h02, 16'h00D4, 0);
        idle_row(1, 4'd4, 32'h04, 16'h01D0, 0);
        idle_row(1, 4'd6, 32'h06, 16'h01C0, 0);
        idle_row(1, 4'd7, 32'h07, 16'h0180, 0);
        idle_row(1, 4'd8, 32'h08, 16'h0100, 0);
        idle_row(0, 4'd8, 32'h08, 16'h0000, 1);
        add(0, 1, 4'd9, 32'h09, 1, 4'd10, 32'h0A,      1, 1, 0, 4'd8, 32'h08, 16'h0000, 1);
        add(0, 1, 4'd11, 32'h0B, 1, 4'd12, 32'h0C,     1, 1, 0, 4'd8, 32'h08, 16'h0600, 0);
        add(1, 1, 4'd13, 32'h0D, 0, 0, 0,              1, 0, 1, 4'd9, 32'h09, 16'h1E00, 0);
        idle_row(0, 4'd0, 32'h0, 16'h0000, 1);
        idle_row(0, 4'd0, 32'h0, 16'h0000, 1);
        idle_row(0, 4'd0, 32'h0, 16'h0000, 1);

        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            alu_valid_i = vecs[i].av; alu_r_i = vecs[i].ar; alu_data_i = vecs[i].ad;
            lsu_valid_i = vecs[i].lv; lsu_r_i = vecs[i].lr; lsu_data_i = vecs[i].ld;
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready_o}, {31'd0, vecs[i].e_ar});
            chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready_o}, {31'd0, vecs[i].e_lr});
            chk($sformatf("v%0d_wb", i), {31'd0, wb_o}, {31'd0, vecs[i].e_wb});
            chk($sformatf("v%0d_wb_r", i), {28'd0, wb_r_o}, {28'd0, vecs[i].e_wbr});
            chk($sformatf("v%0d_result", i), result_o, vecs[i].e_res);
            chk($sformatf("v%0d_pending", i), {16'd0, pending_o}, {16'd0, vecs[i].e_pend});
            chk($sformatf("v%0d_empty", i), {31'd0, empty_o}, {31'd0, vecs[i].e_empty});
            @(posedge clk); #1;
        end
        rst = 0; alu_valid_i = 0; lsu_valid_i = 0;

        // Both producers valid every cycle, distinct registers 0..15.
        for (int k = 0; k < 8; k++) begin
            alu_src.push_back('{r: 4'(2 * k),     d: 32'h100 + 32'(2 * k)});
            lsu_src.push_back('{r: 4'(2 * k + 1), d: 32'h200 + 32'(2 * k + 1)});
        end
        run_stream("fill", 0, 16, 1);

        // Alternating single and dual enqueues, enough to wrap the pointers repeatedly.
        for (int k = 0; k < 10; k++) begin
            alu_src.push_back('{r: 4'($urandom_range(0, 15)), d: $urandom});
            if (k % 2 == 1) lsu_src.push_back('{r: 4'($urandom_range(0, 15)), d: $urandom});
        end
        run_stream("wrap", 1, 15, 0);

        @(negedge clk);
        chk("final_empty", {31'd0, empty_o}, 32'd1);
        chk("final_pending", {16'd0, pending_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
